// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate issue controller: extension selects,
// opcode/subop encodings and the per-instruction classification record.
package imm_pkg;

    typedef enum logic [1:0] {
        EXT_ZE5  = 2'd0,
        EXT_SE15 = 2'd1,
        EXT_ZE15 = 2'd2,
        EXT_SE20 = 2'd3
    } ext_sel_t;

    // Major opcodes, instr[30:25]
    localparam logic [5:0] OpcAlu1  = 6'h20;
    localparam logic [5:0] OpcAddi  = 6'h28;
    localparam logic [5:0] OpcSubri = 6'h29;
    localparam logic [5:0] OpcLwi   = 6'h02;
    localparam logic [5:0] OpcSwi   = 6'h0A;
    localparam logic [5:0] OpcAndi  = 6'h2A;
    localparam logic [5:0] OpcXori  = 6'h2B;
    localparam logic [5:0] OpcOri   = 6'h2C;
    localparam logic [5:0] OpcMovi  = 6'h22;

    // ALU_1 subops, instr[4:0]
    localparam logic [4:0] SubSlli  = 5'h08;
    localparam logic [4:0] SubSrli  = 5'h09;
    localparam logic [4:0] SubSrai  = 5'h0A;
    localparam logic [4:0] SubRotri = 5'h0B;

    typedef struct packed {
        ext_sel_t sel;
        logic     use_imm;
        logic     illegal;
    } imm_class_t;

    localparam imm_class_t ClassNoImm   = '{sel: EXT_ZE5, use_imm: 1'b0, illegal: 1'b0};
    localparam imm_class_t ClassIllegal = '{sel: EXT_ZE5, use_imm: 1'b0, illegal: 1'b1};

    function automatic imm_class_t imm_class(ext_sel_t sel);
        imm_class_t c;
        c.sel     = sel;
        c.use_imm = 1'b1;
        c.illegal = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/extension.sv
// Shared immediate extension unit: widens a 20-bit instruction field to DSize
// according to the {s1,s0} select.
module extension
    import imm_pkg::*;
#(
    parameter int unsigned DSize = 32
) (
    input  logic [19:0]      instr,
    input  logic             s0,
    input  logic             s1,
    output logic [DSize-1:0] y
);

    ext_sel_t sel;

    assign sel = ext_sel_t'({s1, s0});

    always_comb begin
        y = '0;
        unique case (sel)
            EXT_ZE5:  y = {{(DSize-5){1'b0}}, instr[14:10]};
            EXT_SE15: y = {{(DSize-15){instr[14]}}, instr[14:0]};
            EXT_ZE15: y = {{(DSize-15){1'b0}}, instr[14:0]};
            EXT_SE20: y = {{(DSize-20){instr[19]}}, instr[19:0]};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode.sv
// Combinational opcode classifier: picks the extension select and flags
// immediate use / illegal encodings for one instruction word.
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:0] in_instr,
    output imm_class_t  cls
);

    logic [5:0] opcode;
    logic [4:0] subop;
    logic       unused_fields;

    assign opcode        = in_instr[30:25];
    assign subop         = in_instr[4:0];
    assign unused_fields = ^in_instr[24:5];

    always_comb begin
        cls = ClassNoImm;
        if (in_instr[31]) begin
            cls = ClassIllegal;
        end else begin
            case (opcode)
                OpcAlu1: begin
                    if (subop == SubSlli || subop == SubSrli ||
                        subop == SubSrai || subop == SubRotri) begin
                        cls = imm_class(EXT_ZE5);
                    end else begin
                        cls = ClassNoImm;
                    end
                end
                OpcAddi, OpcSubri, OpcLwi, OpcSwi: cls = imm_class(EXT_SE15);
                OpcAndi, OpcXori, OpcOri:          cls = imm_class(EXT_ZE15);
                OpcMovi:                           cls = imm_class(EXT_SE20);
                default:                           cls = ClassIllegal;
            endcase
        end
    end

endmodule

// File: rtl/imm_issue_ctrl.sv
// Two-slot decode/issue pipeline around the shared extension unit: slot A drives
// the unit, slot B presents the registered immediate to EX with backpressure.
module imm_issue_ctrl
    import imm_pkg::*;
#(
    parameter int unsigned DSize = 32,
    parameter int unsigned CntW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,

    output logic [19:0]      ext_instr,
    output logic             ext_s0,
    output logic             ext_s1,
    input  logic [DSize-1:0] ext_y,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSize-1:0] out_imm,
    output logic             out_use_imm,
    output logic             out_illegal,
    output logic [CntW-1:0]  imm_cnt
);

    imm_class_t dec_class;

    logic       a_valid_q, a_valid_d;
    logic [19:0] a_instr_q, a_instr_d;
    imm_class_t a_class_q, a_class_d;

    logic             b_valid_q, b_valid_d;
    logic [DSize-1:0] b_imm_q, b_imm_d;
    logic             b_use_imm_q, b_use_imm_d;
    logic             b_illegal_q, b_illegal_d;

    logic [CntW-1:0] cnt_q, cnt_d;

    logic b_free;
    logic accept;
    logic advance;
    logic delivered;

    imm_decode u_decode (
        .in_instr (in_instr),
        .cls      (dec_class)
    );

    assign b_free    = !b_valid_q || out_ready;
    assign in_ready  = !flush && (!a_valid_q || b_free);
    assign accept    = in_valid && in_ready;
    assign advance   = a_valid_q && b_free;
    // EX has taken the entry even when a flush lands in the same cycle
    assign delivered = b_valid_q && out_ready;

    always_comb begin
        a_valid_d   = a_valid_q;
        a_instr_d   = a_instr_q;
        a_class_d   = a_class_q;
        b_valid_d   = b_valid_q;
        b_imm_d     = b_imm_q;
        b_use_imm_d = b_use_imm_q;
        b_illegal_d = b_illegal_q;
        cnt_d       = cnt_q;

        if (delivered && b_use_imm_q) begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (accept) begin
            a_instr_d = in_instr[19:0];
            a_class_d = dec_class;
        end

        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else begin
            if (accept) begin
                a_valid_d = 1'b1;
            end else if (advance) begin
                a_valid_d = 1'b0;
            end

            if (advance) begin
                b_valid_d   = 1'b1;
                b_imm_d     = a_class_q.use_imm ? ext_y : '0;
                b_use_imm_d = a_class_q.use_imm;
                b_illegal_d = a_class_q.illegal;
            end else if (out_ready) begin
                b_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q   <= 1'b0;
            a_instr_q   <= '0;
            a_class_q   <= '0;
            b_valid_q   <= 1'b0;
            b_imm_q     <= '0;
            b_use_imm_q <= 1'b0;
            b_illegal_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_instr_q   <= a_instr_d;
            a_class_q   <= a_class_d;
            b_valid_q   <= b_valid_d;
            b_imm_q     <= b_imm_d;
            b_use_imm_q <= b_use_imm_d;
            b_illegal_q <= b_illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ext_instr   = a_instr_q;
    assign ext_s0      = a_class_q.sel[0];
    assign ext_s1      = a_class_q.sel[1];
    assign out_valid   = b_valid_q;
    assign out_imm     = b_imm_q;
    assign out_use_imm = b_use_imm_q;
    assign out_illegal = b_illegal_q;
    assign imm_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Bench for imm_issue_ctrl with the extension unit attached; a queue-based model
// is compared every cycle and directed cases pin known immediates.
module tb_imm_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [19:0] ext_instr;
    logic        ext_s0;
    logic        ext_s1;
    logic [31:0] ext_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_illegal;
    logic [15:0] imm_cnt;

    always #5 clk = ~clk;

    extension #(.DSize(32)) u_ext (
        .instr (ext_instr),
        .s0    (ext_s0),
        .s1    (ext_s1),
        .y     (ext_y)
    );

    imm_issue_ctrl #(.DSize(32), .CntW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .ext_instr   (ext_instr),
        .ext_s0      (ext_s0),
        .ext_s1      (ext_s1),
        .ext_y       (ext_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_illegal (out_illegal),
        .imm_cnt     (imm_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void m_class(input logic [31:0] i, output int sel, output bit use_imm,
                                    output bit ill);
        int op;
        int sub;
        op      = int'(i[30:25]);
        sub     = int'(i[4:0]);
        sel     = 0;
        use_imm = 0;
        ill     = 0;
        if (i[31]) ill = 1;
        else if (op == 32) begin
            if (sub >= 8 && sub <= 11) use_imm = 1;
        end
        else if (op == 40 || op == 41 || op == 2 || op == 10) begin sel = 1; use_imm = 1; end
        else if (op >= 42 && op <= 44) begin sel = 2; use_imm = 1; end
        else if (op == 34) begin sel = 3; use_imm = 1; end
        else ill = 1;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        int          sel;
        bit          u;
        bit          il;
        logic [31:0] v;
        m_class(i, sel, u, il);
        if (!u) return 32'h0;
        case (sel)
            0: v = (i >> 10) & 32'h1F;
            1: begin
                v = i & 32'h7FFF;
                if (v >= 32'h4000) v = v - 32'h8000;
            end
            2: v = i & 32'h7FFF;
            default: begin
                v = i & 32'hF_FFFF;
                if (v >= 32'h8_0000) v = v - 32'h10_0000;
            end
        endcase
        return v;
    endfunction

    typedef struct {
        logic [31:0] instr;
        bit          in_b;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_cnt;
    logic [31:0] seen[$];

    always @(posedge clk or negedge rst_n) begin
        int   sel;
        bit   u;
        bit   il;
        bit   bv;
        bit   av;
        bit   rdy;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_cnt = 16'h0;
        end else begin
            bv  = mq.size() > 0 && mq[0].in_b;
            av  = mq.size() > 0 && !mq[$].in_b;
            rdy = !flush && (!av || !bv || out_ready);
            if (bv && out_ready) begin
                m_class(mq[0].instr, sel, u, il);
                if (u) m_cnt = m_cnt + 16'h1;
                void'(mq.pop_front());
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && !mq[0].in_b) begin
                    e = mq.pop_front();
                    e.in_b = 1;
                    mq.push_front(e);
                end
                if (in_valid && rdy) begin
                    e.instr = in_instr;
                    e.in_b  = 0;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        int sel;
        bit u;
        bit il;
        bit bv;
        bit av;
        if (rst_n) begin
            bv = mq.size() > 0 && mq[0].in_b;
            av = mq.size() > 0 && !mq[$].in_b;
            check("m_in_ready", 32'(in_ready), 32'(!flush && (!av || !bv || out_ready)));
            check("m_out_valid", 32'(out_valid), 32'(bv));
            check("m_imm_cnt", 32'(imm_cnt), 32'(m_cnt));
            if (bv) begin
                m_class(mq[0].instr, sel, u, il);
                check("m_out_imm", out_imm, m_imm(mq[0].instr));
                check("m_out_use_imm", 32'(out_use_imm), 32'(u));
                check("m_out_illegal", 32'(out_illegal), 32'(il));
            end
            if (av) begin
                m_class(mq[$].instr, sel, u, il);
                check("m_ext_instr", 32'(ext_instr), mq[$].instr & 32'hF_FFFF);
                check("m_ext_sel", 32'({ext_s1, ext_s0}), 32'(sel));
            end
            if (out_valid && out_ready) seen.push_back(out_imm);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_instr = ins;
        flush    = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: instr 0x%08h never accepted", ins);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ext_instr"}, 32'(ext_instr), 32'h0);
        check({tag, "_ext_sel"}, 32'({ext_s1, ext_s0}), 32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_out_imm"}, out_imm, 32'h0);
        check({tag, "_out_use_imm"}, 32'(out_use_imm), 32'h0);
        check({tag, "_out_illegal"}, 32'(out_illegal), 32'h0);
        check({tag, "_imm_cnt"}, 32'(imm_cnt), 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        #3;
        check_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // model pins: hand-computed immediates
        check("pin_addi", m_imm(32'h5000_4000), 32'hFFFF_C000);
        check("pin_movi", m_imm(32'h4408_0000), 32'hFFF8_0000);
        check("pin_slli", m_imm(32'h4000_0C08), 32'h0000_0003);

        // ADDI
        step(1, 32'h5000_4000, 1, 0);
        check("addi_ext_sel", 32'({ext_s1, ext_s0}), 32'h1);
        check("addi_ext_instr", 32'(ext_instr), 32'h0_4000);
        step(0, 32'h0, 1, 0);
        check("addi_out_valid", 32'(out_valid), 32'h1);
        check("addi_out_imm", out_imm, 32'hFFFF_C000);
        check("addi_use_imm", 32'(out_use_imm), 32'h1);
        step(0, 32'h0, 1, 0);
        check("addi_cnt", 32'(imm_cnt), 32'h1);

        // ORI then MOVI back-to-back
        step(1, 32'h5800_7FFF, 1, 0);
        check("ori_in_ready", 32'(in_ready), 32'h1);
        step(1, 32'h4408_0000, 1, 0);
        check("ori_out_imm", out_imm, 32'h0000_7FFF);
        check("movi_in_ready", 32'(in_ready), 32'h1);
        step(0, 32'h0, 1, 0);
        check("movi_out_imm", out_imm, 32'hFFF8_0000);
        step(0, 32'h0, 1, 0);
        check("ori_movi_cnt", 32'(imm_cnt), 32'h3);

        // SLLI then illegal opcode 0x3F
        step(1, 32'h4000_0C08, 1, 0);
        check("slli_ext_sel", 32'({ext_s1, ext_s0}), 32'h0);
        check("slli_ext_instr", 32'(ext_instr), 32'h0_0C08);
        step(1, 32'h7E00_0000, 1, 0);
        check("slli_out_imm", out_imm, 32'h3);
        step(0, 32'h0, 1, 0);
        check("ill_out_illegal", 32'(out_illegal), 32'h1);
        check("ill_out_imm", out_imm, 32'h0);
        check("ill_use_imm", 32'(out_use_imm), 32'h0);
        step(0, 32'h0, 1, 0);
        check("ill_cnt", 32'(imm_cnt), 32'h4);

        // backpressure: 4 ADDIs, EX stalled for 5 cycles
        base = seen.size();
        step(1, 32'h5000_0001, 0, 0);
        step(1, 32'h5000_0002, 0, 0);
        check("stall_in_ready", 32'(in_ready), 32'h0);
        check("stall_out_imm0", out_imm, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h5000_0003, 0, 0);
            check("stall_in_ready_hold", 32'(in_ready), 32'h0);
            check("stall_out_hold", out_imm, 32'h1);
            check("stall_out_valid_hold", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        push(32'h5000_0003);
        push(32'h5000_0004);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        check("stall_count", 32'(seen.size() - base), 32'h4);
        for (int k = 0; k < 4 && base + k < seen.size(); k++)
            check("stall_order", seen[base + k], 32'(k + 1));

        // flush with both slots full
        out_ready = 1'b0;
        push(32'h5000_0005);
        push(32'h5000_0006);
        step(1, 32'h5000_0007, 0, 1);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        push(32'h5000_0008);
        check("post_flush_empty", 32'(out_valid), 32'h0);
        step(0, 32'h0, 1, 0);
        check("post_flush_valid", 32'(out_valid), 32'h1);
        check("post_flush_imm", out_imm, 32'h8);
        step(0, 32'h0, 1, 0);

        // transfer coinciding with flush is still counted
        push(32'h5000_0009);
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 1, 1);
        step(0, 32'h0, 1, 0);

        // counter wrap
        n = 0;
        while (m_cnt != 16'hFFFC && n < 70000) begin
            step(1, 32'h5000_0001, 1, 0);
            n++;
        end
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        push(32'h5000_0007);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        check("cnt_ffff", 32'(imm_cnt), 32'hFFFF);
        push(32'h5000_0007);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        check("cnt_wrap", 32'(imm_cnt), 32'h0);

        // asynchronous reset mid-stream
        step(1, 32'h5000_4000, 0, 0);
        step(1, 32'h5800_7FFF, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(32'h5000_4000);
        step(0, 32'h0, 1, 0);
        check("after_reset_imm", out_imm, 32'hFFFF_C000);
        step(0, 32'h0, 1, 0);
        check("after_reset_cnt", 32'(imm_cnt), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
